// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types and constants for the Gray decoder datapath
//               (binary-to-BCD stage and 7-segment drivers).
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // One BCD digit, legal values 0..9
    typedef logic [3:0] bcd_digit_t;

    // Largest legal BCD digit value
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Legal WIDTH range for the converter (63 keeps tens at or below 9)
    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 6;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/units_if.sv
`default_nettype none
// ============================================================================
// Module      : units_if
// Description : Valid-qualified binary input / BCD output bundle for the
//               units converter stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface units_if
    import decoder_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] binary_code;
    logic             out_valid;
    bcd_digit_t       binary_units;
    bcd_digit_t       binary_tens;

    // Upstream side: supplies the code, observes the digits
    modport master (
        output in_valid,
        output binary_code,
        input  out_valid,
        input  binary_units,
        input  binary_tens
    );

    // Converter side
    modport slave (
        input  in_valid,
        input  binary_code,
        output out_valid,
        output binary_units,
        output binary_tens
    );

endinterface : units_if
`default_nettype wire

// File: rtl/units_bin2bcd_comb.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_comb
// Description : Combinational double-dabble (shift-and-add-3) converter from
//               a WIDTH-bit unsigned value to a units and tens BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_comb
    import decoder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] binary,
    output bcd_digit_t            units,
    output bcd_digit_t            tens
);

    // Scratch register: {tens, units, binary}; binary bits shift into units
    logic [WIDTH+7:0] shift_reg;

    // Unrolled double-dabble: correct each BCD nibble >= 5 by +3, then shift
    always_comb begin
        shift_reg = {8'd0, binary};
        for (int i = 0; i < WIDTH; i++) begin
            if (shift_reg[WIDTH+3:WIDTH] >= 4'd5)
                shift_reg[WIDTH+3:WIDTH] = shift_reg[WIDTH+3:WIDTH] + 4'd3;
            if (shift_reg[WIDTH+7:WIDTH+4] >= 4'd5)
                shift_reg[WIDTH+7:WIDTH+4] = shift_reg[WIDTH+7:WIDTH+4] + 4'd3;
            shift_reg = shift_reg << 1;
        end
        units = shift_reg[WIDTH+3:WIDTH];
        tens  = shift_reg[WIDTH+7:WIDTH+4];
    end

endmodule : bin2bcd_comb
`default_nettype wire

// File: rtl/units.sv
`default_nettype none
// ============================================================================
// Module      : units
// Description : Registered binary-to-BCD stage (units + tens digits) with a
//               one-cycle valid pipeline. Outputs hold when no valid input.
// Revision    : 1.0 - initial release
// ============================================================================
module units
    import decoder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    units_if.slave    bus
);

    // Reject widths whose maximum value would not fit in two BCD digits
    // (or that are too narrow for the Gray datapath)
    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("units: WIDTH=%0d outside legal range 4..6", WIDTH);
        end
    endgenerate

    bcd_digit_t conv_units;
    bcd_digit_t conv_tens;

    bin2bcd_comb #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .binary (bus.binary_code),
        .units  (conv_units),
        .tens   (conv_tens)
    );

    // Valid pipeline flag; cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.out_valid <= 1'b0;
        else
            bus.out_valid <= bus.in_valid;
    end

    // Digit registers load only on valid input, otherwise hold last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.binary_units <= 4'd0;
            bus.binary_tens  <= 4'd0;
        end else if (bus.in_valid) begin
            bus.binary_units <= conv_units;
            bus.binary_tens  <= conv_tens;
        end
    end

endmodule : units
`default_nettype wire

// File: tb/tb_units.sv
`default_nettype none
// ============================================================================
// Module      : tb_units
// Description : Self-checking bench for units at WIDTH=4 and WIDTH=6 against
//               a mod-10 / div-10 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_units;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance
    logic       m4_valid, m6_valid;
    logic [3:0] m4_units, m4_tens, m6_units, m6_tens;

    int perm [64];

    units_if #(.WIDTH(4)) bus4 ();
    units_if #(.WIDTH(6)) bus6 ();

    units #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    units #(.WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".v4"}, int'(bus4.out_valid),    int'(m4_valid));
        check_eq({tag, ".u4"}, int'(bus4.binary_units), int'(m4_units));
        check_eq({tag, ".t4"}, int'(bus4.binary_tens),  int'(m4_tens));
        check_eq({tag, ".v6"}, int'(bus6.out_valid),    int'(m6_valid));
        check_eq({tag, ".u6"}, int'(bus6.binary_units), int'(m6_units));
        check_eq({tag, ".t6"}, int'(bus6.binary_tens),  int'(m6_tens));
        check_eq({tag, ".bcd4"}, int'(bus4.binary_units <= 4'd9 && bus4.binary_tens <= 4'd9), 1);
        check_eq({tag, ".bcd6"}, int'(bus6.binary_units <= 4'd9 && bus6.binary_tens <= 4'd9), 1);
    endtask

    task automatic model_reset();
        m4_valid = 1'b0; m4_units = 4'd0; m4_tens = 4'd0;
        m6_valid = 1'b0; m6_units = 4'd0; m6_tens = 4'd0;
    endtask

    // Drive one cycle on both instances, then check one step after the edge
    task automatic step(input string tag, input logic v4, input int c4,
                        input logic v6, input int c6);
        bus4.in_valid    = v4;
        bus4.binary_code = 4'(c4);
        bus6.in_valid    = v6;
        bus6.binary_code = 6'(c6);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m4_valid = v4;
            if (v4) begin
                m4_units = 4'(c4 % 16 % 10);
                m4_tens  = 4'(c4 % 16 / 10);
            end
            m6_valid = v6;
            if (v6) begin
                m6_units = 4'(c6 % 64 % 10);
                m6_tens  = 4'(c6 % 64 / 10);
            end
        end
        check_all(tag);
    endtask

    initial begin
        model_reset();
        bus4.in_valid = 1'b1; bus4.binary_code = 4'hF;
        bus6.in_valid = 1'b1; bus6.binary_code = 6'h3F;

        // Reset held with valid input present
        for (int i = 0; i < 4; i++) step("rst_hold", 1'b1, 15, 1'b1, 63);
        rst_n = 1'b1;

        // Sweep 10..15 and the WIDTH=6 spot values
        for (int c = 10; c <= 15; c++) step("sweep_hi", 1'b1, c, 1'b1, c);
        step("w6_63", 1'b1, 0, 1'b1, 63);
        step("w6_40", 1'b1, 5, 1'b1, 40);
        step("w6_19", 1'b1, 9, 1'b1, 19);

        // Sweep 0..9 then the 9 -> 10 boundary pair
        for (int c = 0; c <= 9; c++) step("sweep_lo", 1'b1, c, 1'b1, c);
        step("bnd_10", 1'b1, 10, 1'b1, 10);

        // Valid gap: outputs hold, code ignored
        step("gap_12", 1'b1, 12, 1'b1, 12);
        step("gap_hold", 1'b0, 7, 1'b0, 7);
        step("gap_hold2", 1'b0, 3, 1'b0, 55);

        // Asynchronous reset mid-cycle clears without a clock edge
        step("pre_async", 1'b1, 13, 1'b1, 47);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("async_held", 1'b1, 14, 1'b1, 33);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 11, 1'b1, 58);

        // Exhaustive in random order with random valid gaps
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j;
            int tmp;
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0)
                step("rnd_gap", 1'b0, int'($urandom_range(0, 15)),
                     1'b0, int'($urandom_range(0, 63)));
            step("rnd", 1'b1, perm[i] % 16, 1'b1, perm[i]);
        end
        // Full 0..15 coverage for the narrow instance regardless of order
        for (int c = 0; c < 16; c++) step("exh4", 1'b1, c, 1'b1, 63 - c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_units
`default_nettype wire

// File: doc/units.md
Name: units

Overview:
- Converts an unsigned binary code (default 4 bits, 0..15) into a BCD units digit plus a BCD tens digit.
- Registered, single-cycle-latency stage with a valid qualifier.
- Sits between the Gray-to-binary decoder and the 7-segment display drivers of the Gray decoder datapath.
- Example: input 4'b1100 (12) -> binary_units 4'b0010, binary_tens 4'b0001.

Parameters:
- WIDTH, 4, width of binary_code. Legal range 4..6 (max value 63 keeps tens at or below 9). Any other value triggers an elaboration-time $error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  binary_code is valid this cycle.
- binary_code  input  WIDTH  unsigned binary value to convert.
- out_valid  output  1  registered copy of in_valid; qualifies the BCD outputs.
- binary_units  output  4  BCD units digit (value mod 10), range 0..9.
- binary_tens  output  4  BCD tens digit (value / 10), range 0..6.

Behaviour:
- Reset:
  - rst_n low asynchronously forces out_valid=0, binary_units=4'd0, binary_tens=4'd0.
  - Release is synchronous to clk in effect: the first capture happens on the first rising edge with rst_n high.
  - Reset asserted mid-operation discards any in-flight result immediately.
- Conversion:
  - Purely combinational double-dabble (shift-and-add-3) over WIDTH bits feeds the output registers.
  - No division operator.
- Latency: exactly 1 cycle. On each rising edge with in_valid=1, the registers load the units and tens digits of binary_code; out_valid becomes 1.
- Hold: on a rising edge with in_valid=0, out_valid becomes 0 and binary_units/binary_tens hold their previous values.
- No backpressure: a new valid input is accepted every cycle. Back-to-back inputs produce back-to-back outputs in order.
- Arithmetic:
  - binary_units = binary_code mod 10; binary_tens = binary_code / 10.
  - Both outputs are always valid BCD (never 10..15).
- Boundaries:
  - Input 9 -> units 9, tens 0.
  - Input 10 -> units 0, tens 1.
  - Input 15 -> units 5, tens 1.
  - Input 0 -> units 0, tens 0.
  - For WIDTH=6, input 63 -> units 3, tens 6.
- X-safety: binary_code is ignored when in_valid=0; outputs never go X after reset.

Decomposition:
- Shared package (decoder_pkg):
  - BCD digit typedef (4-bit logic).
  - constant BCD_MAX = 9.
  - Used by the 7-segment driver.
- One natural sub-module: bin2bcd_comb, the combinational double-dabble core (parameter WIDTH; outputs units and tens).
- units wraps bin2bcd_comb with the valid pipeline register and reset.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, binary_code=4'b1111 over several edges -> out_valid=0, binary_units=0, binary_tens=0 throughout. Assert rst_n=0 asynchronously mid-cycle -> outputs clear without waiting for clk.
- Sweep 10..15, one per cycle, in_valid=1 (4'b1010, 1011, 1100, 1101, 1110, 1111):
  - Next cycle binary_units = 0000, 0001, 0010, 0011, 0100, 0101 respectively.
  - binary_tens = 0001 each.
  - out_valid = 1.
- Sweep 0..9 -> binary_units equals input, binary_tens = 0. Boundary pair 9 -> (9,0) then 10 -> (0,1) on consecutive cycles.
- Valid gap: send 12, then in_valid=0 with binary_code=7 -> out_valid drops to 0, binary_units holds 4'b0010, binary_tens holds 4'b0001.
- WIDTH=6 instance: inputs 63, 40, 19 -> (units,tens) = (3,6), (0,4), (9,1), each one cycle after input.
- Exhaustive random check: all 2^WIDTH values against the mod-10 and div-10 reference model; every output digit at or below 9.
